ap_ctrl_chain_master: RTL and testbench

Host-side initiator for the ap_ctrl_chain register-access protocol. It accepts single read/write commands on a valid/ready command channel and drives ap_start, ap_continue, ap_ce and ap_rst plus addr, wr_data and rd_wr into a DUFT ap_ctrl_chain wrapper. It returns read data and completion status on a valid/ready response channel. A per-transaction timeout resets a hung DUT.

---
 rtl/ap_ctrl_chain_master.sv | 244 ++++++++++++++++++++++++
 tb/tb_ap_ctrl_chain_master.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ap_ctrl_chain_master.sv
// ---------------------------------------------------------------------------
// ap_ctrl_chain_master
//
// Host-side initiator for the ap_ctrl_chain register-access handshake. A
// single read or write command is taken from the command channel, presented
// to the attached block through ap_start/ap_continue with addr, wr_data and
// rd_wr held steady, and the outcome is returned on the response channel.
// If the block fails to finish within TIMEOUT enabled cycles of ap_start,
// the transaction is answered with rsp_err and the block is reset.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_rd_wr, cmd_addr,
//   cmd_wdata                  command payload (1 = read)
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata, rsp_rd_wr,
//   rsp_err                    response payload
//   pause                      freeze request, forces ap_ce low
//   addr, wr_data, rd_wr       request fields driven to the block
//   ap_start, ap_continue,
//   ap_ce, ap_rst              block control
//   ap_return                  combinational read data from the block
//   ap_idle, ap_ready, ap_done block status
// ---------------------------------------------------------------------------
module ap_ctrl_chain_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_rd_wr,
  output logic              rsp_err,
  input  logic              pause,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_wr,
  output logic              ap_start,
  output logic              ap_continue,
  output logic              ap_ce,
  output logic              ap_rst,
  input  logic [DATA_W-1:0] ap_return,
  input  logic              ap_idle,
  input  logic              ap_ready,
  input  logic              ap_done
);

  localparam logic [2:0] ST_RST_DUT   = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_CONT      = 3'd4;
  localparam logic [2:0] ST_RESP      = 3'd5;
  localparam logic [2:0] ST_ERR       = 3'd6;

  // Counter is wide enough to hold TIMEOUT itself; a zero TIMEOUT disables expiry.
  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               TO_EN    = (TIMEOUT != 0);

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              accept_s;
  logic              capture_s;
  logic              expire_s;
  logic              timeout_hit_s;
  logic              cmd_ready_r;
  logic              rsp_valid_r;
  logic              rsp_err_r;
  logic              ap_start_r;
  logic              ap_continue_r;
  logic              ap_rst_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic              rd_wr_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              unused_idle_s;

  // ap_idle is informational only; nothing in the sequencing depends on it.
  assign unused_idle_s = ap_idle;

  assign ap_ce         = ~pause;
  // The enabled cycle now being counted is the TIMEOUT-th one.
  assign timeout_hit_s = TO_EN ? (cnt_r == CNT_LAST) : 1'b0;

  assign cmd_ready   = cmd_ready_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_err     = rsp_err_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_rd_wr   = rd_wr_r;
  assign ap_start    = ap_start_r;
  assign ap_continue = ap_continue_r;
  assign ap_rst      = ap_rst_r;
  assign addr        = addr_r;
  assign wr_data     = wr_data_r;
  assign rd_wr       = rd_wr_r;

  // Next-state selection; block status is ignored while ap_ce is low.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    expire_s    = 1'b0;
    case (state_r)
      ST_RST_DUT: begin
        state_nxt_s = ST_IDLE;
      end
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (!ap_ce) begin
          state_nxt_s = ST_START;
        end else if (ap_ready && ap_done) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_CONT;
        end else if (timeout_hit_s) begin
          expire_s    = 1'b1;
          state_nxt_s = ST_ERR;
        end else if (ap_ready) begin
          state_nxt_s = ST_WAIT_DONE;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_WAIT_DONE: begin
        if (!ap_ce) begin
          state_nxt_s = ST_WAIT_DONE;
        end else if (ap_done) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_CONT;
        end else if (timeout_hit_s) begin
          expire_s    = 1'b1;
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      ST_CONT: begin
        if (ap_ce && !ap_done) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_CONT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      ST_ERR: begin
        if (rsp_ready) begin
          state_nxt_s = ST_RST_DUT;
        end else begin
          state_nxt_s = ST_ERR;
        end
      end
      default: begin
        state_nxt_s = ST_RST_DUT;
      end
    endcase
  end

  // State register; reset restarts the sequence with a block reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_RST_DUT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Control outputs are decoded from the next state so they are registered yet aligned with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ap_rst_r      <= 1'b1;
      cmd_ready_r   <= 1'b0;
      ap_start_r    <= 1'b0;
      ap_continue_r <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_err_r     <= 1'b0;
    end else begin
      ap_rst_r      <= (state_nxt_s == ST_RST_DUT);
      cmd_ready_r   <= (state_nxt_s == ST_IDLE);
      ap_start_r    <= (state_nxt_s == ST_START);
      ap_continue_r <= (state_nxt_s == ST_CONT);
      rsp_valid_r   <= (state_nxt_s == ST_RESP) || (state_nxt_s == ST_ERR);
      rsp_err_r     <= (state_nxt_s == ST_ERR);
    end
  end

  // Request fields are captured at acceptance and held until the next command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r    <= {ADDR_W{1'b0}};
      wr_data_r <= {DATA_W{1'b0}};
      rd_wr_r   <= 1'b0;
    end else if (accept_s) begin
      addr_r    <= cmd_addr;
      wr_data_r <= cmd_wdata;
      rd_wr_r   <= cmd_rd_wr;
    end
  end

  // Read data is sampled when ap_done is seen, while addr still selects the register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata_r <= {DATA_W{1'b0}};
    end else if (capture_s) begin
      rsp_rdata_r <= rd_wr_r ? ap_return : {DATA_W{1'b0}};
    end else if (expire_s) begin
      rsp_rdata_r <= {DATA_W{1'b0}};
    end
  end

  // Timeout counter counts enabled cycles spent waiting on the block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (((state_r == ST_START) || (state_r == ST_WAIT_DONE)) && ap_ce) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ap_ctrl_chain_master.sv
module tb_ap_ctrl_chain_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_rd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_rd_wr, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          pause;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic          rd_wr, ap_start, ap_continue, ap_ce, ap_rst;
  logic [DW-1:0] ap_return;
  logic          ap_idle, ap_ready, ap_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ap_ctrl_chain_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr(cmd_rd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_rd_wr(rsp_rd_wr), .rsp_err(rsp_err), .pause(pause),
    .addr(addr), .wr_data(wr_data), .rd_wr(rd_wr),
    .ap_start(ap_start), .ap_continue(ap_continue), .ap_ce(ap_ce), .ap_rst(ap_rst),
    .ap_return(ap_return), .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done)
  );

  // Behavioural register-file block: ready rdy_lat and done done_lat cycles after ap_start,
  // ap_done held until ap_continue, writes committed on completion.
  int          rdy_lat = 0;
  int          done_lat = 1;
  bit          never_done = 1'b0;
  int          dm_t;
  bit          dm_on, dm_done_h;
  logic [31:0] dut_mem [0:255];

  assign ap_ready  = ap_start && (dm_t == rdy_lat);
  assign ap_done   = !never_done && (dm_done_h || ((dm_on || ap_start) && (dm_t == done_lat)));
  assign ap_return = dut_mem[addr[7:0]];
  assign ap_idle   = !dm_on && !ap_start;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      dm_on <= 1'b0; dm_t <= 0; dm_done_h <= 1'b0;
      for (int i = 0; i < 256; i++) dut_mem[i] <= 32'h0;
    end else if (ap_rst) begin
      dm_on <= 1'b0; dm_t <= 0; dm_done_h <= 1'b0;
    end else if (ap_ce) begin
      if (ap_done && ap_continue) begin
        dm_on <= 1'b0; dm_t <= 0; dm_done_h <= 1'b0;
        if (!rd_wr) dut_mem[addr[7:0]] <= wr_data;
      end else begin
        if (!dm_on && ap_start) begin
          dm_on <= 1'b1; dm_t <= 1;
        end else if (dm_on && !dm_done_h) begin
          dm_t <= dm_t + 1;
        end
        if (ap_done) dm_done_h <= 1'b1;
      end
    end
  end

  // Reference register contents, updated only by writes that complete without error.
  logic [31:0] exp_mem [0:255];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 256; i++) exp_mem[i] = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ap_rst_pulse", ap_rst, 1'b1);
    chk("rst_cmd_ready_low", cmd_ready, 1'b0);
    @(negedge clk);
    chk("rst_ap_rst_done", ap_rst, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_outputs", {ap_start, ap_continue, rsp_valid, rsp_err, rd_wr, rsp_rdata, addr, wr_data},
        {3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0});
  endtask

  // One transaction; expected timing follows from the latencies: done lands in cycle dl+1
  // (plus pause), continue one cycle later, response two cycles after that.
  task automatic run_txn(input bit rd, input logic [31:0] a, input logic [31:0] wd,
                         input int rl, input int dl, input bit nd,
                         input int pa, input int pl, input int hold);
    int          c, rc, cf, sl, exp_rc, exp_cf, exp_sl;
    bit          hold_ok, ce_ok, stable;
    logic [31:0] exp_data, held;
    rdy_lat = rl; done_lat = dl; never_done = nd;
    exp_data = (rd && !nd) ? exp_mem[a[7:0]] : 32'h0;
    if (nd) begin
      exp_rc = TO + 1; exp_sl = TO; exp_cf = 0;
    end else begin
      exp_rc = dl + 4 + pl; exp_sl = rl + 1; exp_cf = dl + 2 + pl;
    end
    c = 0;
    while (!cmd_ready && c < 20) begin @(negedge clk); c++; end
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_rd_wr = rd; cmd_addr = a; cmd_wdata = wd; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_rd_wr = ~rd;
    rc = 0; cf = 0; sl = 0; hold_ok = 1'b1; ce_ok = 1'b1;
    for (c = 1; c <= 200; c++) begin
      pause = (c >= pa) && (c < pa + pl);
      #1;
      if (ap_ce !== !pause) ce_ok = 1'b0;
      if (ap_start) sl = c;
      if (ap_continue && cf == 0) cf = c;
      if ((ap_start || ap_continue) && (addr !== a || rd_wr !== rd || (!rd && wr_data !== wd)))
        hold_ok = 1'b0;
      if (cmd_ready) hold_ok = 1'b0;
      if (rsp_valid) begin rc = c; break; end
      @(negedge clk);
    end
    pause = 1'b0;
    chk("rsp_cycle", rc, exp_rc);
    chk("start_last_cycle", sl, exp_sl);
    if (!nd) chk("cont_first_cycle", cf, exp_cf);
    chk("req_fields_held", hold_ok, 1'b1);
    chk("ap_ce_follows_pause", ce_ok, 1'b1);
    chk("rsp_rdata", rsp_rdata, exp_data);
    chk("rsp_err", rsp_err, nd);
    chk("rsp_rd_wr", rsp_rd_wr, rd);
    held = rsp_rdata; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== held || cmd_ready || rsp_err !== nd) stable = 1'b0;
    end
    if (hold > 0) chk("rsp_stable_backpressure", stable, 1'b1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 1'b0);
    if (nd) begin
      chk("err_ap_rst_pulse", ap_rst, 1'b1);
      chk("err_cmd_ready_low", cmd_ready, 1'b0);
      @(negedge clk);
      chk("err_ap_rst_done", ap_rst, 1'b0);
    end
    chk("back_to_idle", cmd_ready, 1'b1);
    if (!rd && !nd) exp_mem[a[7:0]] = wd;
  endtask

  initial begin
    int rl, dl;
    reset = 1'b1; cmd_valid = 1'b0; cmd_rd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; pause = 1'b0;
    do_reset();

    // Directed: write, read back, backpressure, pause, timeout.
    run_txn(1'b0, 32'h10, 32'hDEADBEEF, 2, 2, 1'b0, 0, 0, 0);
    run_txn(1'b1, 32'h10, 32'h0, 0, 1, 1'b0, 0, 0, 0);
    run_txn(1'b1, 32'h10, 32'h0, 0, 1, 1'b0, 0, 0, 10);
    run_txn(1'b1, 32'h10, 32'h0, 0, 6, 1'b0, 3, 5, 0);
    run_txn(1'b0, 32'h10, 32'h12345678, 99, 99, 1'b1, 0, 0, 2);
    run_txn(1'b1, 32'h10, 32'h0, 0, 1, 1'b0, 0, 0, 0);

    // Randomized mix against the reference register contents.
    for (int n = 0; n < 24; n++) begin
      rl = $urandom_range(2, 0);
      dl = rl + $urandom_range(3, 0);
      run_txn(1'($urandom_range(1, 0)), 32'($urandom_range(31, 0)), $urandom,
              rl, dl, 1'b0, 0, 0, $urandom_range(3, 0));
    end

    // Asynchronous reset while a write is in flight.
    rdy_lat = 0; done_lat = 5; never_done = 1'b0;
    cmd_valid = 1'b1; cmd_rd_wr = 1'b0; cmd_addr = 32'h10; cmd_wdata = 32'hCAFEF00D;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ap_rst", ap_rst, 1'b1);
    chk("midrst_outputs", {ap_start, ap_continue, cmd_ready, rsp_valid, addr, wr_data},
        {4'b0000, 32'h0, 32'h0});
    do_reset();
    run_txn(1'b1, 32'h10, 32'h0, 0, 1, 1'b0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
